// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with run-time op select, feeding an elastic valid/ready
// pipeline that carries each result together with its zero/ones/parity flags.

module logic_unit_stage #(
   parameter int PW = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld,
   input  logic          src_vld,
   input  logic [PW-1:0] src_dat,
   output logic          vld,
   output logic [PW-1:0] dat
);
   // Payload only moves when a real item arrives, so a stalled or drained
   // stage keeps its last contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= 1'b0;
         dat <= '0;
      end else if (ld) begin
         vld <= src_vld;
         if (src_vld) dat <= src_dat;
      end
   end
endmodule

module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_zero,
   output logic             y_ones,
   output logic             y_parity,
   output logic [CNT_W-1:0] done_cnt
);
   typedef struct packed {
      logic [WIDTH-1:0] y;
      logic             zero;
      logic             ones;
      logic             parity;
   } res_t;

   localparam int PW = $bits(res_t);

   if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("logic_unit_pipe: DEPTH must be 1..4");
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("logic_unit_pipe: WIDTH must be >= 1");
   end

   // Index 0 is the input side; index k+1 is pipeline stage k.
   logic [DEPTH:0] vld_pipe;
   res_t [DEPTH:0] dat_pipe;
   logic           rdy [0:DEPTH];
   res_t           in_res;
   logic [WIDTH-1:0] r;

   always_comb begin
      r = '0;
      case (op)
         3'b000: r = a & b;
         3'b001: r = a | b;
         3'b010: r = a ^ b;
         3'b011: r = ~(a & b);
         3'b100: r = ~(a | b);
         3'b101: r = ~(a ^ b);
         3'b110: r = a & ~b;
         default: r = a;
      endcase
      in_res        = '0;
      in_res.y      = r;
      in_res.zero   = (r == '0);
      in_res.ones   = (r == '1);
      in_res.parity = ^r;
   end

   assign vld_pipe[0] = in_valid;
   assign dat_pipe[0] = in_res;
   assign rdy[DEPTH]  = out_ready;

   // A stage can load when it is empty or its occupant leaves this cycle;
   // the ready chain runs back from the consumer, never through in_valid.
   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      assign rdy[k] = ~vld_pipe[k+1] | rdy[k+1];
      logic_unit_stage #(.PW(PW)) u_stage (
         .clk     (clk),
         .rst     (rst),
         .ld      (rdy[k]),
         .src_vld (vld_pipe[k]),
         .src_dat (dat_pipe[k]),
         .vld     (vld_pipe[k+1]),
         .dat     (dat_pipe[k+1])
      );
   end

   assign in_ready  = rdy[0];
   assign out_valid = vld_pipe[DEPTH];
   assign y         = dat_pipe[DEPTH].y;
   assign y_zero    = dat_pipe[DEPTH].zero;
   assign y_ones    = dat_pipe[DEPTH].ones;
   assign y_parity  = dat_pipe[DEPTH].parity;

   always_ff @(posedge clk) begin
      if (rst) done_cnt <= '0;
      else if (out_valid && out_ready && done_cnt != '1) done_cnt <= done_cnt + CNT_W'(1);
   end
endmodule
